// File: rtl/piece_drop_sequencer.sv
// piece_drop_sequencer: spawn / fall / lock / clear game sequencer.
// Optional SOFT_DROP_EN macro adds a soft_drop input with faster ticks.
module piece_drop_sequencer #(
    parameter int TICK_DIV = 12500000,
    parameter int SCORE_W  = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [2:0]         next_piece,
    input  logic               move_finish,
    input  logic               spawn_blocked,
    input  logic               clear_done,
    input  logic [2:0]         lines_cleared,
`ifdef SOFT_DROP_EN
    input  logic               soft_drop,
`endif
    output logic               move_en,
    output logic [2:0]         piece_code,
    output logic               lock,
    output logic               clear_req,
    output logic               game_over,
    output logic [2:0]         state_o,
    output logic [SCORE_W-1:0] score
);

    localparam int CW = $clog2(TICK_DIV);
    localparam logic [CW-1:0] TICK_MAX = CW'(TICK_DIV - 1);
`ifdef SOFT_DROP_EN
    localparam logic [CW:0] SOFT_LIM = (CW+1)'(TICK_DIV / 8);
`endif

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] SPAWN = 3'd1;
    localparam logic [2:0] FALL  = 3'd2;
    localparam logic [2:0] LOCK  = 3'd3;
    localparam logic [2:0] CLEAR = 3'd4;
    localparam logic [2:0] OVER  = 3'd5;

    logic [2:0]    state;
    logic [2:0]    state_nx;
    logic [CW-1:0] cnt;
    logic          tick;
    logic          soft_pt;
    logic [3:0]    pts;
    logic          move_en_nx;
    logic          lock_nx;
    logic          clear_nx;
    logic          over_nx;

    // Saturating add so the score pins at all-ones instead of wrapping.
    function automatic logic [SCORE_W-1:0] sat_add(
        input logic [SCORE_W-1:0] a,
        input logic [3:0]         b
    );
        logic [SCORE_W:0] s;
        s = {1'b0, a} + (SCORE_W+1)'(b);
        return s[SCORE_W] ? '1 : s[SCORE_W-1:0];
    endfunction

    // Drop tick: normal period, or shortened threshold while soft dropping.
    always_comb begin
        tick    = (cnt == TICK_MAX);
        soft_pt = 1'b0;
`ifdef SOFT_DROP_EN
        if (soft_drop) begin
            tick = (({1'b0, cnt} + (CW+1)'(1)) >= SOFT_LIM);
        end
        soft_pt = soft_drop && tick && !move_finish && !start
                  && (state == FALL);
`endif
    end

    // Points per clear; anything above four rows scores as four.
    always_comb begin
        case (lines_cleared)
            3'd0:    pts = 4'd0;
            3'd1:    pts = 4'd1;
            3'd2:    pts = 4'd3;
            3'd3:    pts = 4'd5;
            default: pts = 4'd8;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic; start restarts from any active state.
    always_comb begin
        state_nx = IDLE;
        case (state)
            IDLE: begin
                state_nx = start ? SPAWN : IDLE;
            end
            SPAWN: begin
                if (start)              state_nx = SPAWN;
                else if (spawn_blocked) state_nx = OVER;
                else                    state_nx = FALL;
            end
            FALL: begin
                if (start)                    state_nx = SPAWN;
                else if (tick && move_finish) state_nx = LOCK;
                else                          state_nx = FALL;
            end
            LOCK: begin
                state_nx = start ? SPAWN : CLEAR;
            end
            CLEAR: begin
                if (start || clear_done) state_nx = SPAWN;
                else                     state_nx = CLEAR;
            end
            OVER: begin
                state_nx = start ? SPAWN : OVER;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Output decode from the next state, registered below.
    always_comb begin
        move_en_nx = (state_nx == FALL) && (state == FALL)
                     && tick && !move_finish;
        lock_nx    = (state_nx == LOCK);
        clear_nx   = (state_nx == CLEAR);
        over_nx    = (state_nx == OVER);
    end

    // Registered control outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            move_en   <= 1'b0;
            lock      <= 1'b0;
            clear_req <= 1'b0;
            game_over <= 1'b0;
        end else begin
            move_en   <= move_en_nx;
            lock      <= lock_nx;
            clear_req <= clear_nx;
            game_over <= over_nx;
        end
    end

    // Gravity counter: runs only in FALL, wraps on each drop tick.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (state != FALL || start || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    // Active piece code, latched only while spawning.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            piece_code <= 3'd0;
        end else if (state == SPAWN) begin
            piece_code <= (next_piece == 3'd7) ? 3'd0 : next_piece;
        end
    end

    // Score: cleared by start, credited on clears and soft-dropped rows.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            score <= '0;
        end else if (start) begin
            score <= '0;
        end else if (state == CLEAR && clear_done) begin
            score <= sat_add(score, pts);
        end else if (soft_pt) begin
            score <= sat_add(score, 4'd1);
        end
    end

    assign state_o = state;

endmodule

// File: tb/tb_piece_drop_sequencer.sv
// tb_piece_drop_sequencer: directed plus randomized game rounds
// checked against a spec-level score/timing model.
module tb_piece_drop_sequencer;

    localparam int TD = 8;
    localparam int SW = 4;
    localparam int SMAX = (1 << SW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [2:0]    next_piece = 3'd0;
    logic          move_finish = 1'b0;
    logic          spawn_blocked = 1'b0;
    logic          clear_done = 1'b0;
    logic [2:0]    lines_cleared = 3'd0;
`ifdef SOFT_DROP_EN
    logic          soft_drop = 1'b0;
`endif
    logic          move_en;
    logic [2:0]    piece_code;
    logic          lock;
    logic          clear_req;
    logic          game_over;
    logic [2:0]    state_o;
    logic [SW-1:0] score;

    int checks = 0;
    int failures = 0;
    int exp_score = 0;
    int exp_code = 0;
    int pts_tab[8] = '{0, 1, 3, 5, 8, 8, 8, 8};
    int lines_seq[6] = '{1, 2, 3, 0, 3, 4};
    int code_seq[6] = '{2, 7, 4, 6, 1, 5};

    piece_drop_sequencer #(.TICK_DIV(TD), .SCORE_W(SW)) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .next_piece(next_piece),
        .move_finish(move_finish),
        .spawn_blocked(spawn_blocked),
        .clear_done(clear_done),
        .lines_cleared(lines_cleared),
`ifdef SOFT_DROP_EN
        .soft_drop(soft_drop),
`endif
        .move_en(move_en),
        .piece_code(piece_code),
        .lock(lock),
        .clear_req(clear_req),
        .game_over(game_over),
        .state_o(state_o),
        .score(score)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int add_sat(input int a, input int b);
        return (a + b > SMAX) ? SMAX : a + b;
    endfunction

    task automatic chk_idle_outs(input string tag);
        chk({tag, "_state"}, state_o, 0);
        chk({tag, "_move_en"}, move_en, 0);
        chk({tag, "_lock"}, lock, 0);
        chk({tag, "_clear_req"}, clear_req, 0);
        chk({tag, "_game_over"}, game_over, 0);
        chk({tag, "_piece"}, piece_code, 0);
        chk({tag, "_score"}, score, 0);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
        exp_score = 0;
        chk("start_state", state_o, 1);
        chk("start_score", score, 0);
        chk("start_clear_req", clear_req, 0);
        chk("start_game_over", game_over, 0);
        chk("start_move_en", move_en, 0);
    endtask

    task automatic spawn(input int code, input bit blocked);
        next_piece = 3'(code);
        spawn_blocked = blocked;
        step();
        spawn_blocked = 1'b0;
        exp_code = (code == 7) ? 0 : code;
        chk("spawn_piece", piece_code, exp_code);
        chk("spawn_state", state_o, blocked ? 5 : 2);
        chk("spawn_game_over", game_over, blocked ? 1 : 0);
        chk("spawn_move_en", move_en, 0);
    endtask

    // Piece falls through 'drops' full tick periods, then lands in the next.
    task automatic fall(input int drops, input int off, input bit spur);
        for (int d = 0; d <= drops; d++) begin
            for (int i = 0; i < TD; i++) begin
                bit last;
                last = (d == drops);
                if (last && i == off) move_finish = 1'b1;
                if (!last && spur && i == 2) move_finish = 1'b1;
                if (!last && spur && i == 4) move_finish = 1'b0;
                if (spur && i == 5) begin
                    clear_done = 1'b1;
                    lines_cleared = 3'd4;
                end
                step();
                clear_done = 1'b0;
                chk("fall_score", score, exp_score);
                chk("fall_piece", piece_code, exp_code);
                if (i < TD - 1) begin
                    chk("fall_move_en_idle", move_en, 0);
                    chk("fall_state", state_o, 2);
                end else if (last) begin
                    chk("land_move_en", move_en, 0);
                    chk("land_state", state_o, 3);
                    chk("land_lock", lock, 1);
                end else begin
                    chk("tick_move_en", move_en, 1);
                    chk("tick_state", state_o, 2);
                end
            end
        end
        move_finish = 1'b0;
    endtask

    // From LOCK: mode 0 completes the clear, 1 aborts by start, 2 resets.
    task automatic clear_phase(input int waits, input int lines, input int mode);
        step();
        chk("clr_enter_state", state_o, 4);
        chk("clr_enter_req", clear_req, 1);
        chk("clr_lock_low", lock, 0);
        for (int w = 0; w < waits; w++) begin
            step();
            chk("clr_wait_state", state_o, 4);
            chk("clr_wait_req", clear_req, 1);
        end
        if (mode == 0) begin
            clear_done = 1'b1;
            lines_cleared = 3'(lines);
            step();
            clear_done = 1'b0;
            exp_score = add_sat(exp_score, pts_tab[lines]);
            chk("clr_done_state", state_o, 1);
            chk("clr_done_req", clear_req, 0);
            chk("clr_score", score, exp_score);
        end else if (mode == 1) begin
            pulse_start();
        end else begin
            #2 rst = 1'b1;
            #1;
            exp_score = 0;
            exp_code = 0;
            chk_idle_outs("rst_mid_clear");
            #2 rst = 1'b0;
            step();
            chk("rst_after_state", state_o, 0);
        end
    endtask

    initial begin
        step();
        step();
        chk_idle_outs("reset");
        #2 rst = 1'b0;
        step();
        chk("idle_state", state_o, 0);

        next_piece = 3'd3;
        pulse_start();
        spawn(3, 0);
        fall(2, 3, 1);
        clear_phase(2, 4, 0);

        spawn(7, 0);
        for (int i = 0; i < 3; i++) step();
        pulse_start();

        for (int r = 0; r < 6; r++) begin
            spawn(code_seq[r], 0);
            fall(r % 2, r, r[0]);
            clear_phase(r % 3, lines_seq[r], 0);
        end

        spawn(6, 0);
        fall(0, 6, 0);
        clear_phase(1, 0, 1);

        for (int r = 0; r < 6; r++) begin
            spawn(int'($urandom_range(0, 7)), 0);
            fall(int'($urandom_range(0, 2)), int'($urandom_range(0, TD - 1)),
                 1'($urandom_range(0, 1)));
            clear_phase(int'($urandom_range(0, 3)),
                        int'($urandom_range(0, 7)), 0);
        end

        spawn(2, 1);
        for (int i = 0; i < 10; i++) begin
            if (i == 4) begin
                clear_done = 1'b1;
                lines_cleared = 3'd4;
            end
            step();
            clear_done = 1'b0;
            chk("over_state", state_o, 5);
            chk("over_flag", game_over, 1);
            chk("over_move_en", move_en, 0);
            chk("over_score", score, exp_score);
        end
        pulse_start();

        spawn(1, 0);
        fall(1, 0, 0);
        clear_phase(0, 4, 0);
        spawn(4, 0);
        fall(0, 5, 0);
        clear_phase(2, 0, 2);

`ifdef SOFT_DROP_EN
        pulse_start();
        spawn(5, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("pre_soft_move_en", move_en, 0);
        end
        soft_drop = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            exp_score = add_sat(exp_score, 1);
            chk("soft_move_en", move_en, 1);
            chk("soft_score", score, exp_score);
            chk("soft_state", state_o, 2);
        end
        soft_drop = 1'b0;
        for (int i = 0; i < TD; i++) begin
            step();
            chk("post_soft_move_en", move_en, (i == TD - 1) ? 1 : 0);
            chk("post_soft_score", score, exp_score);
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
